// File: rtl/viu_pkg.sv
// viu_pkg
// Shared constants and types for the VIU receive-side route-tag filter.
// Holds the expected TPID, route field positions, the reserved-bit mask,
// the drop reason encoding and the byte geometry of one AXI-Stream beat.
package viu_pkg;

  // One 512-bit AXI-Stream beat carries 64 bytes; stripping the 4-byte tag
  // leaves 60 bytes to carry forward between beats.
  localparam int BEAT_BYTES = 64;
  localparam int HOLD_BYTES = BEAT_BYTES - 4;

  localparam logic [15:0] VIU_TPID = 16'h8100;

  // Field positions inside the 14-bit route carried in the TCI.
  localparam int SND_LSB  = 6;
  localparam int SND_MSB  = 9;
  localparam int PORT_LSB = 0;
  localparam int PORT_MSB = 1;

  // route[13:10] and route[5:2] must be zero.
  localparam logic [13:0] RSVD_MASK = 14'h3C3C;

  typedef enum logic [1:0] {
    DROP_NONE = 2'd0,
    DROP_TPID = 2'd1,
    DROP_RSVD = 2'd2,
    DROP_PERM = 2'd3
  } drop_reason_t;

endpackage

// File: rtl/viu_rx_realign.sv
// viu_rx_realign
// Removes the 4-byte 802.1Q tag from an accepted frame and realigns the
// stream. A 60-byte hold register carries the tail of the previous beat;
// every output beat is the hold contents followed by the first 4 bytes of
// the current input beat. The output is a single registered stage.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_data/keep/last current input beat (from the upstream stream)
//   hdr_load         accepted header beat: load hold with bytes 0-11,16-63
//   strm_beat        body beat consumed: emit hold ++ in[0..3], refill hold
//   flush_emit       emit the leftover hold contents as the final beat
//   m_axis_*         registered output stream
//   out_free         output stage can take a new beat this cycle
module viu_rx_realign
  import viu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BEAT_BYTES*8-1:0]   in_data,
  input  logic [BEAT_BYTES-1:0]     in_keep,
  input  logic                      in_last,
  input  logic                      hdr_load,
  input  logic                      strm_beat,
  input  logic                      flush_emit,
  input  logic                      m_axis_tready,
  output logic [BEAT_BYTES*8-1:0]   m_axis_tdata,
  output logic [BEAT_BYTES-1:0]     m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  output logic                      out_free
);

  localparam int DW = BEAT_BYTES * 8;
  localparam int HW = HOLD_BYTES * 8;

  logic [HW-1:0]         hold_data;
  logic [HOLD_BYTES-1:0] hold_keep;

  assign out_free = !m_axis_tvalid || m_axis_tready;

  // The hold register keeps the bytes that did not fit into the beat just
  // emitted. Its keep mask travels with it so the final flush beat knows how
  // many bytes are real. Because upstream keep is contiguous, a body beat's
  // keep is simply the hold keep with the first 4 input keep bits on top,
  // and the final beat only gets tlast here when no bytes spill past byte 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data     <= '0;
      hold_keep     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (hdr_load) begin
        hold_data <= {in_data[DW-1:128], in_data[95:0]};
        hold_keep <= {in_keep[BEAT_BYTES-1:16], in_keep[11:0]};
      end else if (strm_beat) begin
        hold_data <= in_data[DW-1:32];
        hold_keep <= in_keep[BEAT_BYTES-1:4];
      end

      if (strm_beat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {in_data[31:0], hold_data};
        m_axis_tkeep  <= {in_keep[3:0], hold_keep};
        m_axis_tlast  <= in_last && !in_keep[4];
      end else if (flush_emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {32'd0, hold_data};
        m_axis_tkeep  <= {4'd0, hold_keep};
        m_axis_tlast  <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/viu_rx_vlan_filter.sv
// viu_rx_vlan_filter
// Receive-side enforcement of the VIU route tag. The header beat of every
// frame is checked (TPID, length, reserved bits, sender->destination
// permission); accepted frames have their tag stripped, rejected frames are
// swallowed whole and counted.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   rx_perm           bit [d*N_SND+s]: destination d accepts sender s
//   s_axis_*          tagged frames from CMAC
//   m_axis_*          untagged accepted frames
//   route_out         route of the last accepted frame
//   route_valid       one-cycle pulse per accepted frame
//   port_out          destination port of the last accepted frame
//   drop_cnt          saturating dropped-frame counter
//   drop_reason       reason of the most recent drop
module viu_rx_vlan_filter
  import viu_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int N_ID       = 4,
  parameter int N_SND      = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_ID*N_SND-1:0]   rx_perm,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [13:0]             route_out,
  output logic                    route_valid,
  output logic [1:0]              port_out,
  output logic [31:0]             drop_cnt,
  output logic [1:0]              drop_reason
);

  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_STRM  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_LAST  = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  logic [2:0]   state;
  logic         s_ready;
  logic         s_fire;
  logic         out_free;
  logic [15:0]  tpid;
  logic [15:0]  tci;
  logic [13:0]  route;
  logic [3:0]   sender;
  logic [1:0]   port;
  logic         perm_bit;
  drop_reason_t hdr_reason;
  logic         hdr_accept;

  // Header fields; byte 12 is the most significant TPID byte on the wire.
  assign tpid   = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
  assign tci    = {s_axis_tdata[14*8 +: 8], s_axis_tdata[15*8 +: 8]};
  assign route  = tci[13:0];
  assign sender = route[SND_MSB:SND_LSB];
  assign port   = route[PORT_MSB:PORT_LSB];

  // Permission lookup. Only ports below N_ID and senders below N_SND have a
  // bit in rx_perm; anything outside that range finds no match and is
  // treated as denied.
  always_comb begin
    perm_bit = 1'b0;
    for (int d = 0; d < N_ID; d++) begin
      for (int s = 0; s < N_SND; s++) begin
        if (port == 2'(d) && sender == 4'(s)) begin
          perm_bit = rx_perm[d*N_SND + s];
        end
      end
    end
  end

  // Header verdict with fixed priority: framing problems first (a runt
  // header cannot be trusted to hold a TPID), then reserved bits, then
  // permission. keep is contiguous, so bit 15 set means at least 16 bytes.
  always_comb begin
    hdr_reason = DROP_NONE;
    if (!s_axis_tkeep[15] || tpid != VIU_TPID) begin
      hdr_reason = DROP_TPID;
    end else if (tci[15:14] != 2'b00 || (route & RSVD_MASK) != 14'd0) begin
      hdr_reason = DROP_RSVD;
    end else if (!perm_bit) begin
      hdr_reason = DROP_PERM;
    end
  end

  assign hdr_accept = (hdr_reason == DROP_NONE);

  // Input backpressure follows the output stage while the realigner may
  // emit, is always open while discarding, and is closed while the leftover
  // hold bytes are being flushed.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      ST_HDR, ST_STRM: s_ready = out_free;
      ST_DROP:         s_ready = 1'b1;
      default:         s_ready = 1'b0;
    endcase
  end

  assign s_axis_tready = s_ready;
  assign s_fire        = s_axis_tvalid && s_ready;

  // Frame FSM plus the exported route/port and drop statistics. The
  // permission decision is taken once on the header beat, so later changes
  // of rx_perm cannot affect a frame already in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ST_HDR;
      route_out   <= '0;
      port_out    <= '0;
      route_valid <= 1'b0;
      drop_cnt    <= '0;
      drop_reason <= '0;
    end else begin
      route_valid <= 1'b0;
      case (state)
        ST_HDR: begin
          if (s_fire) begin
            if (hdr_accept) begin
              route_out   <= route;
              port_out    <= port;
              route_valid <= 1'b1;
              state       <= s_axis_tlast ? ST_LAST : ST_STRM;
            end else begin
              drop_reason <= hdr_reason;
              if (drop_cnt != 32'hFFFF_FFFF) begin
                drop_cnt <= drop_cnt + 32'd1;
              end
              state <= s_axis_tlast ? ST_HDR : ST_DROP;
            end
          end
        end
        ST_STRM: begin
          if (s_fire && s_axis_tlast) begin
            state <= s_axis_tkeep[4] ? ST_FLUSH : ST_HDR;
          end
        end
        ST_FLUSH, ST_LAST: begin
          if (out_free) begin
            state <= ST_HDR;
          end
        end
        ST_DROP: begin
          if (s_fire && s_axis_tlast) begin
            state <= ST_HDR;
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  viu_rx_realign u_realign (
    .clk           (aclk),
    .rst           (areset),
    .in_data       (s_axis_tdata),
    .in_keep       (s_axis_tkeep),
    .in_last       (s_axis_tlast),
    .hdr_load      (state == ST_HDR && s_fire && hdr_accept),
    .strm_beat     (state == ST_STRM && s_fire),
    .flush_emit    ((state == ST_FLUSH || state == ST_LAST) && out_free),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .out_free      (out_free)
  );

endmodule

// File: tb/tb_viu_rx_vlan_filter.sv
// tb_viu_rx_vlan_filter
// Scoreboard bench: each frame is run through a byte-level reference model
// that pushes the expected untagged beats and routes into queues; a monitor
// pops and compares whenever the DUT hands over a beat or pulses route_valid.
module tb_viu_rx_vlan_filter;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int N_ID  = 2;
  localparam int N_SND = 16;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic [N_ID*N_SND-1:0] rx_perm = '0;
  logic [DW-1:0]         s_axis_tdata = '0;
  logic [KW-1:0]         s_axis_tkeep = '0;
  logic                  s_axis_tlast = 1'b0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic [DW-1:0]         m_axis_tdata;
  logic [KW-1:0]         m_axis_tkeep;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b1;
  logic [13:0]           route_out;
  logic                  route_valid;
  logic [1:0]            port_out;
  logic [31:0]           drop_cnt;
  logic [1:0]            drop_reason;

  always #5 aclk = ~aclk;

  viu_rx_vlan_filter #(.DATA_WIDTH(DW), .N_ID(N_ID), .N_SND(N_SND)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .rx_perm       (rx_perm),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .route_out     (route_out),
    .route_valid   (route_valid),
    .port_out      (port_out),
    .drop_cnt      (drop_cnt),
    .drop_reason   (drop_reason)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [13:0] exp_route_q[$];
  int          total = 0;
  int          bad = 0;
  int          model_drops = 0;
  int          model_reason = 0;
  logic [7:0]  fr [0:511];
  int          fr_len = 0;
  bit          random_ready = 1'b0;

  // Output-side flow control: always ready, or a coin flip per cycle.
  always @(posedge aclk) begin
    #1 m_axis_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares handed-over beats and route pulses against the queues
  // and checks that a stalled beat does not change.
  beat_t         mon_exp;
  beat_t         held;
  bit            stalled = 1'b0;
  logic [DW-1:0] mask;
  logic [13:0]   exp_route;

  always @(negedge aclk) begin
    if (areset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held.data ||
            m_axis_tkeep !== held.keep || m_axis_tlast !== held.last) begin
          bad++;
          $display("[TB] FAIL stall_hold got keep=%h last=%b valid=%b want keep=%h last=%b valid=1",
                   m_axis_tkeep, m_axis_tlast, m_axis_tvalid, held.keep, held.last);
        end
      end
      stalled = 1'b0;
      if (m_axis_tvalid === 1'b1) begin
        if (m_axis_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_beat got keep=%h last=%b want no beat", m_axis_tkeep, m_axis_tlast);
          end else begin
            mon_exp = exp_q.pop_front();
            mask = '0;
            for (int j = 0; j < KW; j++) if (mon_exp.keep[j]) mask[j*8 +: 8] = 8'hFF;
            if (m_axis_tkeep !== mon_exp.keep || m_axis_tlast !== mon_exp.last) begin
              bad++;
              $display("[TB] FAIL beat_ctrl got keep=%h last=%b want keep=%h last=%b",
                       m_axis_tkeep, m_axis_tlast, mon_exp.keep, mon_exp.last);
            end else if ((m_axis_tdata & mask) !== mon_exp.data) begin
              bad++;
              $display("[TB] FAIL beat_data got=%h want=%h", m_axis_tdata & mask, mon_exp.data);
            end
          end
        end else begin
          stalled = 1'b1;
          held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
      end
      if (route_valid === 1'b1) begin
        total++;
        if (exp_route_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_route got=%h want no pulse", route_out);
        end else begin
          exp_route = exp_route_q.pop_front();
          if (route_out !== exp_route || port_out !== exp_route[1:0]) begin
            bad++;
            $display("[TB] FAIL route got route=%h port=%0d want route=%h port=%0d",
                     route_out, port_out, exp_route, exp_route[1:0]);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic build_frame(input int len, input logic [15:0] tpid, input logic [15:0] tci);
    fr_len = len;
    for (int i = 0; i < 512; i++) fr[i] = 8'($urandom);
    fr[12] = tpid[15:8];
    fr[13] = tpid[7:0];
    fr[14] = tci[15:8];
    fr[15] = tci[7:0];
  endtask

  // Reference model: decide the frame from the tag rules, then produce the
  // output as the frame bytes minus bytes 12..15, cut into 64-byte beats.
  task automatic model_frame(input logic [N_ID*N_SND-1:0] perm);
    logic [7:0] outb[$];
    int         reason;
    int         rt;
    int         snd;
    int         prt;
    beat_t      b;
    reason = 0;
    rt  = (int'(fr[14]) * 256 + int'(fr[15])) % 16384;
    snd = (rt / 64) % 16;
    prt = rt % 4;
    if (fr_len < 16 || fr[12] != 8'h81 || fr[13] != 8'h00) reason = 1;
    else if (fr[14] >= 8'h40 || (rt / 1024) != 0 || ((rt / 4) % 16) != 0) reason = 2;
    else if (prt >= N_ID || snd >= N_SND || perm[prt*N_SND + snd] == 1'b0) reason = 3;
    if (reason != 0) begin
      model_drops++;
      model_reason = reason;
    end else begin
      for (int i = 0; i < fr_len; i++) if (i < 12 || i > 15) outb.push_back(fr[i]);
      exp_route_q.push_back(14'(rt));
      while (outb.size() > 0) begin
        b = '0;
        for (int j = 0; j < KW && outb.size() > 0; j++) begin
          b.data[j*8 +: 8] = outb.pop_front();
          b.keep[j] = 1'b1;
        end
        b.last = (outb.size() == 0);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_beat();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      done = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL s_tready_timeout got=0 want=1");
    end
  endtask

  // Drives the frame in fr[] (at most max_beats beats, all if negative);
  // rx_perm is scrambled after the header so a late change must not matter.
  task automatic applyStimulus(input logic [N_ID*N_SND-1:0] perm, input int max_beats);
    int nb;
    int n;
    model_frame(perm);
    nb = (fr_len + 63) / 64;
    for (int b = 0; b < nb && (max_beats < 0 || b < max_beats); b++) begin
      n = (fr_len - b*64 > 64) ? 64 : fr_len - b*64;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int j = 0; j < n; j++) begin
        s_axis_tdata[j*8 +: 8] = fr[b*64 + j];
        s_axis_tkeep[j] = 1'b1;
      end
      s_axis_tlast  = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      if (b == 0) rx_perm = perm;
      send_beat();
      if (b == 0) rx_perm = $urandom;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3000 && (exp_q.size() > 0 || exp_route_q.size() > 0); c++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("drain_beats_left", exp_q.size(), 0);
    checkOutput("drain_routes_left", exp_route_q.size(), 0);
  endtask

  task automatic check_drops();
    checkOutput("drop_cnt", drop_cnt, model_drops);
    checkOutput("drop_reason", {30'd0, drop_reason}, model_reason);
  endtask

  initial begin
    int         len;
    int         snd;
    int         prt;
    logic [13:0] rt;
    logic [15:0] tpid;

    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset_m_tvalid", {31'd0, m_axis_tvalid}, 0);
    checkOutput("reset_drop_cnt", drop_cnt, 0);
    checkOutput("reset_route_out", {18'd0, route_out}, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // 128-byte frame, sender 1 port 1, permitted by bit 17.
    build_frame(128, 16'h8100, 16'h0041);
    applyStimulus(32'h0002_0000, -1);
    drain();
    checkOutput("port_out_after_accept", {30'd0, port_out}, 1);

    // Last beat of exactly 4 bytes, then one of 6 bytes.
    build_frame(68, 16'h8100, 16'h0041);
    applyStimulus(32'h0002_0000, -1);
    build_frame(70, 16'h8100, 16'h0041);
    applyStimulus(32'h0002_0000, -1);
    drain();

    // Wrong TPID, then a good frame.
    build_frame(128, 16'h0800, 16'h0041);
    applyStimulus(32'hFFFF_FFFF, -1);
    check_drops();
    checkOutput("drop_cnt_first", drop_cnt, 1);
    build_frame(100, 16'h8100, 16'h0000);
    applyStimulus(32'h0000_0001, -1);
    drain();

    // Reserved bit, port beyond N_ID, sender not permitted.
    build_frame(90, 16'h8100, 16'h0402);
    applyStimulus(32'hFFFF_FFFF, -1);
    check_drops();
    checkOutput("reason_reserved", {30'd0, drop_reason}, 2);
    build_frame(90, 16'h8100, 16'h0043);
    applyStimulus(32'hFFFF_FFFF, -1);
    check_drops();
    build_frame(90, 16'h8100, 16'h0140);
    applyStimulus(32'hFFFF_FFDF, -1);
    check_drops();
    checkOutput("reason_perm", {30'd0, drop_reason}, 3);

    // Runt header, single-beat frames of 40 and 16 bytes.
    build_frame(12, 16'h8100, 16'h0041);
    applyStimulus(32'hFFFF_FFFF, -1);
    check_drops();
    build_frame(40, 16'h8100, 16'h0041);
    applyStimulus(32'h0002_0000, -1);
    build_frame(16, 16'h8100, 16'h0041);
    applyStimulus(32'h0002_0000, -1);
    drain();
    check_drops();

    // Randomised frames under random output backpressure.
    random_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(8, 200);
      snd = $urandom_range(0, 15);
      prt = $urandom_range(0, 3);
      rt  = 14'(snd * 64 + prt);
      if ($urandom_range(0, 9) == 0) rt = rt | 14'(1 << $urandom_range(0, 13));
      tpid = ($urandom_range(0, 9) == 0) ? 16'h88A8 : 16'h8100;
      build_frame(len, tpid, {2'b00, rt});
      applyStimulus($urandom | 32'h0001_0001, -1);
      check_drops();
    end
    drain();
    random_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset in the middle of a streaming frame.
    build_frame(192, 16'h8100, 16'h0041);
    applyStimulus(32'h0002_0000, 2);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("midreset_m_tvalid", {31'd0, m_axis_tvalid}, 0);
    checkOutput("midreset_m_tkeep", m_axis_tkeep[31:0], 0);
    checkOutput("midreset_route_out", {18'd0, route_out}, 0);
    checkOutput("midreset_port_out", {30'd0, port_out}, 0);
    checkOutput("midreset_drop_cnt", drop_cnt, 0);
    checkOutput("midreset_drop_reason", {30'd0, drop_reason}, 0);
    exp_q.delete();
    exp_route_q.delete();
    model_drops  = 0;
    model_reason = 0;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    build_frame(130, 16'h8100, 16'h0001);
    applyStimulus(32'h0000_0001, -1);
    drain();
    check_drops();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
